// File: rtl/text_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | text_pkg : shared constants, command encodings and FSM states for    |
// |            the text RAM arbiter and its cursor sub-module.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package text_pkg;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int COL_W = 7;
  localparam int ROW_W = 5;

  localparam logic [6:0] CHAR_SPACE = 7'h20;

  typedef enum logic [1:0] {
    OP_PUT     = 2'b00,
    OP_HOME    = 2'b01,
    OP_NEWLINE = 2'b10,
    OP_CLEAR   = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/text_cursor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | text_cursor : column/row register pair with advance, newline and     |
// |               home controls; both coordinates wrap without scroll.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module text_cursor #(
  parameter int COLS = text_pkg::COLS,
  parameter int ROWS = text_pkg::ROWS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        advance_i,
  input  logic                        newline_i,
  input  logic                        home_i,
  output logic [text_pkg::COL_W-1:0]  col_o,
  output logic [text_pkg::ROW_W-1:0]  row_o
);

  localparam int CW = text_pkg::COL_W;
  localparam int RW = text_pkg::ROW_W;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] w_row_inc;

  always_comb begin
    w_row_inc = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
    col_d     = col_q;
    row_d     = row_q;
    // home wins over newline, which wins over a plain advance
    if (home_i) begin
      col_d = '0;
      row_d = '0;
    end else if (newline_i) begin
      col_d = '0;
      row_d = w_row_inc;
    end else if (advance_i) begin
      if (col_q == CW'(COLS - 1)) begin
        col_d = '0;
        row_d = w_row_inc;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule
`default_nettype wire

// File: rtl/text_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | text_ram_arbiter : shares a single-port text RAM between the video   |
// |                    font pipeline (fixed priority) and host commands. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module text_ram_arbiter #(
  parameter int COLS   = text_pkg::COLS,
  parameter int ROWS   = text_pkg::ROWS,
  parameter int ADDR_W = 12,
  parameter int CHAR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [CHAR_W-1:0] char_code,
  input  logic              cmd_req,
  input  logic [1:0]        cmd_op,
  input  logic [CHAR_W-1:0] cmd_char,
  output logic              cmd_ack,
  output logic              busy,
  output logic [6:0]        cur_col,
  output logic [4:0]        cur_row,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [CHAR_W-1:0] ram_din,
  input  logic [CHAR_W-1:0] ram_dout
);

  import text_pkg::*;

  state_e            state_q, state_d;
  logic [CHAR_W-1:0] char_q, char_d, char_code_q;
  logic              busy_q, busy_d, ack_q, ack_d, vid_q;
  logic              w_video, w_host_we, w_sw_last;
  logic              w_cur_adv, w_cur_nl, w_cur_home, w_sw_adv;
  logic [COL_W-1:0]  w_sw_col;
  logic [ROW_W-1:0]  w_sw_row;
  logic [ADDR_W-1:0] w_host_addr, w_vid_addr;
  logic [CHAR_W-1:0] w_host_din;
  logic              unused_pix;

  assign unused_pix = ^{pixel_x[2:0], pixel_y[9], pixel_y[3:0]};

  assign w_video    = pixel_tick & video_on;
  assign w_vid_addr = ADDR_W'({pixel_y[8:4], pixel_x[9:3]});
  assign w_sw_last  = (w_sw_row == ROW_W'(ROWS - 1)) && (w_sw_col == COL_W'(COLS - 1));

  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk       (clk),
    .reset     (reset),
    .advance_i (w_cur_adv),
    .newline_i (w_cur_nl),
    .home_i    (w_cur_home),
    .col_o     (cur_col),
    .row_o     (cur_row)
  );

  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_sweep (
    .clk       (clk),
    .reset     (reset),
    .advance_i (w_sw_adv),
    .newline_i (1'b0),
    .home_i    (1'b0),
    .col_o     (w_sw_col),
    .row_o     (w_sw_row)
  );

  always_comb begin
    state_d     = state_q;
    char_d      = char_q;
    busy_d      = busy_q;
    ack_d       = 1'b0;
    w_cur_adv   = 1'b0;
    w_cur_nl    = 1'b0;
    w_cur_home  = 1'b0;
    w_sw_adv    = 1'b0;
    w_host_we   = 1'b0;
    w_host_addr = ADDR_W'({cur_row, cur_col});
    w_host_din  = char_q;
    if (ack_q) busy_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_req && !busy_q) begin
          char_d = cmd_char;
          busy_d = 1'b1;
          case (cmd_op_e'(cmd_op))
            OP_PUT:     state_d = ST_WRITE;
            OP_CLEAR:   state_d = ST_CLEAR;
            OP_HOME:    begin w_cur_home = 1'b1; ack_d = 1'b1; end
            OP_NEWLINE: begin w_cur_nl   = 1'b1; ack_d = 1'b1; end
          endcase
        end
      end
      ST_WRITE: begin
        if (!w_video) begin
          w_host_we = 1'b1;
          w_cur_adv = 1'b1;
          ack_d     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        w_host_addr = ADDR_W'({w_sw_row, w_sw_col});
        w_host_din  = CHAR_W'(CHAR_SPACE);
        if (!w_video) begin
          w_host_we = 1'b1;
          w_sw_adv  = 1'b1;
          // the sweep wraps back to (0,0) on its own after the last cell
          if (w_sw_last) begin
            w_cur_home = 1'b1;
            ack_d      = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      char_q      <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      vid_q       <= 1'b0;
      char_code_q <= '0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      vid_q   <= w_video;
      if (vid_q) char_code_q <= ram_dout;
    end
  end

  // a reset arriving mid-command must not let the in-flight write through
  assign ram_we    = w_host_we & ~reset;
  assign ram_addr  = w_video ? w_vid_addr : w_host_addr;
  assign ram_din   = w_host_din;
  assign char_code = char_code_q;
  assign cmd_ack   = ack_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/text_ram_arbiter.md
# text_ram_arbiter

Shares one single-port synchronous text RAM (one ASCII code per 8x16 character tile) between two requesters. The first is the video font pipeline, which has fixed priority and a hard deadline. The second is a host command port that writes characters at a hardware cursor. The block sits between `vga_sync`/font generation and the text RAM. It supplies the tile code the font generator needs, and sequences host PUT/HOME/NEWLINE/CLEAR commands into spare RAM cycles.

## Interface
Parameters:
- `COLS`, 80, text columns (tile x = `pixel_x[9:3]`)
- `ROWS`, 30, text rows (tile y = `pixel_y[8:4]`)
- `ADDR_W`, 12, RAM address width; address = {row[4:0], col[6:0]}
- `CHAR_W`, 7, character code width

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `pixel_tick`  in  1  pixel enable from `vga_sync`
- `video_on`  in  1  visible-area flag from `vga_sync`
- `pixel_x`, `pixel_y`  in  10 each  current pixel coordinates
- `char_code`  out  CHAR_W  registered tile code for the font generator
- `cmd_req`  in  1  host command request; held until `cmd_ack`
- `cmd_op`  in  2  00 PUT, 01 HOME, 10 NEWLINE, 11 CLEAR
- `cmd_char`  in  CHAR_W  character for PUT
- `cmd_ack`  out  1  one-cycle completion pulse
- `busy`  out  1  command in progress
- `cur_col`  out  7  cursor column, 0..COLS-1
- `cur_row`  out  5  cursor row, 0..ROWS-1
- `ram_addr`  out  ADDR_W  RAM address
- `ram_we`  out  1  RAM write enable
- `ram_din`  out  CHAR_W  RAM write data
- `ram_dout`  in  CHAR_W  RAM read data, valid one cycle after the address

## Operation
- Video slot is any cycle with `pixel_tick & video_on`:
  - `ram_addr` = {`pixel_y[8:4]`, `pixel_x[9:3]`}, `ram_we` = 0.
  - Host access is never granted in a video slot.
- Every other cycle is a host slot.
- FSM states and transitions:
  - IDLE: on `cmd_req & ~busy`, capture `cmd_op` and `cmd_char`.
    - PUT → WRITE.
    - CLEAR → CLEAR.
    - HOME and NEWLINE complete in IDLE: cursor update and `cmd_ack` on the next cycle; no RAM access.
  - WRITE: waits for the first host slot. In that slot it drives `ram_we`=1, addr = {cur_row, cur_col}, din = char. It then advances the cursor, pulses `cmd_ack` and returns to IDLE.
  - CLEAR: a sweep counter writes 0x20 (space) to every row 0..ROWS-1, col 0..COLS-1 cell, row-major, one cell per host slot. It stalls on video slots. After the last cell (29,79) it sets the cursor to (0,0), pulses `cmd_ack` and returns to IDLE.
- Cursor advance:
  - col+1; at col = COLS-1, col → 0 and row+1.
  - At row = ROWS-1, row → 0 (wrap, no scroll).
  - NEWLINE: col → 0, row+1 with the same wrap rule.
- `cmd_req` while `busy` is ignored; no queuing.
- Host writes never target cells with col ≥ COLS or row ≥ ROWS.
- Reset values:
  - FSM → IDLE.
  - `busy`, `cmd_ack`, `ram_we` = 0.
  - `cur_col` = `cur_row` = 0.
  - `char_code` = 0.
  - Sweep counter = 0.
- Reset during WRITE or CLEAR aborts immediately: no further RAM writes, and no `cmd_ack`.

## Timing
- Video read latency:
  - Address is driven in tick cycle t.
  - `ram_dout` is valid in t+1.
  - `char_code` is registered at the end of t+1 and visible in t+2.
  - Loaded only after video slots; holds otherwise.
- `busy` rises the cycle after the command is accepted. It falls in the cycle after the `cmd_ack` pulse.
- Host may drop `cmd_req` in the cycle following `cmd_ack`. A new command is accepted once `busy` = 0.
- PUT latency:
  - ≥2 cycles from acceptance to `cmd_ack`.
  - Bounded by the next host slot: with a 50 MHz `clk` and `pixel_tick` every 2nd cycle, the worst case is 3 cycles.
- CLEAR takes ROWS·COLS = 2400 host slots; worst case about 4800 cycles in the visible area.
- Cursor outputs update in the same cycle as `cmd_ack`.

## Structure
- Shared package `text_pkg`:
  - COLS, ROWS.
  - `cmd_op` encodings (OP_PUT, OP_HOME, OP_NEWLINE, OP_CLEAR).
  - CHAR_SPACE = 7'h20.
  - FSM state encoding.
- Sub-module `text_cursor`:
  - col/row register pair with advance, newline and home controls plus wrap logic.
  - Instantiated twice: once for the cursor, once for the CLEAR sweep counter.

## Test plan
- Reset, then PUT 'A' (0x41) at idle with `video_on`=0 → one write at addr 0x000 with data 0x41; `cmd_ack` 2 cycles after acceptance; cursor (0,1).
- Cursor set to (0,79) via 79 PUTs, then PUT 'B' → write at addr {0,79}=0x04F; cursor (1,0). Cursor at (29,79), then PUT → cursor wraps to (0,0).
- PUT issued while `pixel_tick & video_on` are continuously high for 3 cycles → `ram_we` stays 0 during those cycles; the write lands in the first host slot; video reads are undisturbed.
- Tick at `pixel_x`=0x010, `pixel_y`=0x020 with RAM cell {2,2} holding 0x33 → `ram_addr`=0x102; `char_code`=0x33 two cycles later.
- CLEAR → exactly 2400 writes of 0x20 covering all valid cells; no writes to cols 80..127; cursor (0,0); one `cmd_ack`. Second `cmd_req` mid-sweep is ignored.
- Reset asserted mid-CLEAR → `ram_we` is 0 from the reset cycle on, no `cmd_ack`, cursor (0,0), `busy` 0.
